// File: rtl/io_clk_pkg.sv
// Shared types and default divide constants for the I/O reset sequencer and clock-enable generator.
package io_clk_pkg;

  typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} rstseq_state_t;

  localparam int PROC_CLK_DIVIDE = 3;
  localparam int VGA_CLK_DIVIDE  = 2;

endpackage

// File: rtl/io_clken_div.sv
// Per-channel clock-enable divider: one-cycle strobe every DIVIDE cycles while the channel is out of reset.
module io_clken_div #(
  parameter int              DIV_W  = 8,
  parameter logic [DIV_W-1:0] DIVIDE = DIV_W'(1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic clk_en
);

  localparam logic [DIV_W-1:0] LAST = DIVIDE - 1'b1;

  if (DIVIDE == '0) begin : g_bad_divide
    $error("io_clken_div: DIVIDE must be non-zero");
  end

  logic [DIV_W-1:0] div_cnt;

  // Held at zero while in reset so the first strobe lands DIVIDE-1 cycles after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (hold || (div_cnt == LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign clk_en = ~hold & (div_cnt == LAST);

endmodule

// File: rtl/io_reset_clken_gen.sv
// Reset sequencer: synchronises the MMCM lock, stretches reset, releases channels in order,
// and drives one clock-enable divider per channel on the single system clock.
module io_reset_clken_gen
  import io_clk_pkg::*;
#(
  parameter int                      NUM_CH        = 2,
  parameter int                      DIV_W         = 8,
  parameter logic [NUM_CH*DIV_W-1:0] CH_DIVIDE     = {DIV_W'(VGA_CLK_DIVIDE), DIV_W'(PROC_CLK_DIVIDE)},
  parameter int                      SYNC_STAGES   = 2,
  parameter int                      RESET_STRETCH = 16,
  parameter int                      RELEASE_GAP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked_in,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic              all_ready
);

  localparam int STRETCH_W = (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH) : 1;
  localparam int GAP_W     = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RESET_STRETCH - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST     = GAP_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("io_reset_clken_gen: NUM_CH must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_reset_clken_gen: SYNC_STAGES must be at least 2");
  end
  if ((RESET_STRETCH < 1) || (RELEASE_GAP < 1)) begin : g_bad_timing
    $error("io_reset_clken_gen: RESET_STRETCH and RELEASE_GAP must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   lock_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lock_sync = sync_ff[SYNC_STAGES-1];

  rstseq_state_t         state, state_next;
  logic [STRETCH_W-1:0]  stretch_cnt, stretch_next;
  logic [GAP_W-1:0]      gap_cnt, gap_next;
  logic [IDX_W-1:0]      idx, idx_next, idx_inc;
  logic [NUM_CH-1:0]     rst_next;
  logic                  ready_next;
  logic                  abort;

  assign abort   = ~lock_sync | soft_rst_req;
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      rst_out     <= '1;
      all_ready   <= 1'b0;
    end else begin
      state       <= state_next;
      stretch_cnt <= stretch_next;
      gap_cnt     <= gap_next;
      idx         <= idx_next;
      rst_out     <= rst_next;
      all_ready   <= ready_next;
    end
  end

  // Abort outranks every other transition; once out of HOLD any lock loss or soft request re-resets all.
  always_comb begin
    state_next   = state;
    stretch_next = stretch_cnt;
    gap_next     = gap_cnt;
    idx_next     = idx;
    rst_next     = rst_out;
    ready_next   = all_ready;

    if ((state != HOLD) && abort) begin
      state_next   = HOLD;
      stretch_next = '0;
      gap_next     = '0;
      idx_next     = '0;
      rst_next     = '1;
      ready_next   = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (!abort) begin
            state_next   = STRETCH;
            stretch_next = '0;
          end
        end
        STRETCH: begin
          if (stretch_cnt == STRETCH_LAST) begin
            rst_next[0] = 1'b0;
            idx_next    = '0;
            gap_next    = '0;
            if (NUM_CH == 1) begin
              state_next = RUN;
              ready_next = 1'b1;
            end else begin
              state_next = RELEASE;
            end
          end else begin
            stretch_next = stretch_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            idx_next          = idx_inc;
            gap_next          = '0;
            rst_next[idx_inc] = 1'b0;
            if (idx_inc == IDX_LAST) begin
              state_next = RUN;
              ready_next = 1'b1;
            end
          end else begin
            gap_next = gap_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    io_clken_div #(
      .DIV_W  (DIV_W),
      .DIVIDE (CH_DIVIDE[i*DIV_W +: DIV_W])
    ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (rst_out[i]),
      .clk_en (clk_en[i])
    );
  end

endmodule

// File: tb/tb_io_reset_clken_gen.sv
// Directed bench: release timing, strobe patterns, lock loss, soft reset and async reset on a 3-channel build.
module tb_io_reset_clken_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, locked_in, soft_rst_req;
  logic [1:0] rst_out, clk_en;
  logic       all_ready;

  logic       rst_n_b, locked_b, soft_b;
  logic [2:0] rst_out_b, clk_en_b;
  logic       all_ready_b;

  int checks   = 0;
  int failures = 0;

  io_reset_clken_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked_in    (locked_in),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out),
    .clk_en       (clk_en),
    .all_ready    (all_ready)
  );

  io_reset_clken_gen #(
    .NUM_CH    (3),
    .DIV_W     (8),
    .CH_DIVIDE ({8'd1, 8'd5, 8'd4})
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n_b),
    .locked_in    (locked_b),
    .soft_rst_req (soft_b),
    .rst_out      (rst_out_b),
    .clk_en       (clk_en_b),
    .all_ready    (all_ready_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lock_val, input logic soft_val);
    @(negedge clk);
    locked_in    = lock_val;
    soft_rst_req = soft_val;
  endtask

  // Expected strobe pattern over 64 edges for a channel released at edge rel with divide d.
  function automatic logic [63:0] expStrobes(input int rel, input int d);
    logic [63:0] v;
    v = '0;
    for (int e = 0; e < 64; e++) begin
      if ((e >= rel + d - 1) && (((e - (rel + d - 1)) % d) == 0)) v[e] = 1'b1;
    end
    return v;
  endfunction

  // Observes 64 edges; edge 0 is the first posedge after the caller's stimulus.
  task automatic measureRelease(input bit use_b, output int r0, output int r1, output int r2,
                                output int rdy, output logic [63:0] v0, output logic [63:0] v1,
                                output logic [63:0] v2);
    logic [2:0] rs, en;
    logic       ry;
    r0 = -1; r1 = -1; r2 = -1; rdy = -1;
    v0 = '0; v1 = '0; v2 = '0;
    for (int e = 0; e < 64; e++) begin
      @(posedge clk);
      #1;
      rs = use_b ? rst_out_b : {1'b1, rst_out};
      en = use_b ? clk_en_b : {1'b0, clk_en};
      ry = use_b ? all_ready_b : all_ready;
      if (!rs[0] && r0 < 0) r0 = e;
      if (!rs[1] && r1 < 0) r1 = e;
      if (!rs[2] && r2 < 0) r2 = e;
      if (ry && rdy < 0) rdy = e;
      v0[e] = en[0];
      v1[e] = en[1];
      v2[e] = en[2];
    end
  endtask

  int          r0, r1, r2, rdy;
  logic [63:0] v0, v1, v2;
  logic        early;

  initial begin
    rst_n = 1'b0; locked_in = 1'b0; soft_rst_req = 1'b0;
    rst_n_b = 1'b0; locked_b = 1'b0; soft_b = 1'b0;
    #12;
    checkOutput("reset_rst_out", 64'(rst_out), 64'(2'b11));
    checkOutput("reset_clk_en", 64'(clk_en), 64'(2'b00));
    checkOutput("reset_all_ready", 64'(all_ready), 64'(1'b0));
    checkOutput("reset_rst_out_b", 64'(rst_out_b), 64'(3'b111));

    // Power-up sequence with lock present from the first edge.
    @(negedge clk);
    rst_n = 1'b1; locked_in = 1'b1;
    measureRelease(1'b0, r0, r1, r2, rdy, v0, v1, v2);
    checkOutput("pwr_rel_ch0", 64'(r0), 64'(18));
    checkOutput("pwr_rel_ch1", 64'(r1), 64'(22));
    checkOutput("pwr_all_ready", 64'(rdy), 64'(22));
    checkOutput("pwr_strobe_ch0", v0, expStrobes(18, 3));
    checkOutput("pwr_strobe_ch1", v1, expStrobes(22, 2));

    // Lock lost for three cycles while running.
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("lockloss_ready_still", 64'(all_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    checkOutput("lockloss_rst_out", 64'(rst_out), 64'(2'b11));
    checkOutput("lockloss_clk_en", 64'(clk_en), 64'(2'b00));
    checkOutput("lockloss_all_ready", 64'(all_ready), 64'(1'b0));
    applyStimulus(1'b1, 1'b0);
    measureRelease(1'b0, r0, r1, r2, rdy, v0, v1, v2);
    checkOutput("relock_rel_ch0", 64'(r0), 64'(18));
    checkOutput("relock_rel_ch1", 64'(r1), 64'(22));

    // Lock drops when the stretch counter reaches 10.
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    repeat (13) @(posedge clk);
    applyStimulus(1'b0, 1'b0);
    early = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rst_out != 2'b11) early = 1'b1;
    end
    checkOutput("stretch_abort_no_release", 64'(early), 64'(1'b0));
    applyStimulus(1'b1, 1'b0);
    measureRelease(1'b0, r0, r1, r2, rdy, v0, v1, v2);
    checkOutput("stretch_restart_ch0", 64'(r0), 64'(18));
    checkOutput("stretch_restart_ch1", 64'(r1), 64'(22));

    // One-cycle soft reset while only ch0 is released.
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("soft_pre_rst_out", 64'(rst_out), 64'(2'b10));
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("soft_abort_rst_out", 64'(rst_out), 64'(2'b11));
    applyStimulus(1'b1, 1'b0);
    r0 = -1; r1 = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (!rst_out[0] && r0 < 0) r0 = e;
      if (!rst_out[1] && r1 < 0) r1 = e;
    end
    checkOutput("soft_reseq_ch0", 64'(r0), 64'(17));
    checkOutput("soft_reseq_ch1", 64'(r1), 64'(21));

    // Three-channel build: async reset mid-release, then divide 4/5/1 after relock.
    @(negedge clk);
    rst_n_b = 1'b1; locked_b = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    checkOutput("b_mid_release", 64'(rst_out_b), 64'(3'b100));
    @(negedge clk);
    rst_n_b = 1'b0;
    #1;
    checkOutput("b_async_rst_out", 64'(rst_out_b), 64'(3'b111));
    checkOutput("b_async_clk_en", 64'(clk_en_b), 64'(3'b000));
    checkOutput("b_async_all_ready", 64'(all_ready_b), 64'(1'b0));
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    measureRelease(1'b1, r0, r1, r2, rdy, v0, v1, v2);
    checkOutput("b_rel_ch0", 64'(r0), 64'(18));
    checkOutput("b_rel_ch1", 64'(r1), 64'(22));
    checkOutput("b_rel_ch2", 64'(r2), 64'(26));
    checkOutput("b_all_ready", 64'(rdy), 64'(26));
    checkOutput("b_strobe_ch0", v0, expStrobes(18, 4));
    checkOutput("b_strobe_ch1", v1, expStrobes(22, 5));
    checkOutput("b_strobe_ch2", v2, expStrobes(26, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
